// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port MIPS register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;

  // MIPS register indices
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 31;

  // Address width for a file of num_regs entries; never narrower than 1 bit.
  function automatic int unsigned addr_width(input int unsigned num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by reservations, cleared by completed writes.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_REGS-1:0] set_vec,
  input  logic [NUM_REGS-1:0] clr_vec,
  output logic [NUM_REGS-1:0] busy
);

  // A reservation landing with a write belongs to a newer producer, so set wins.
  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~clr_vec) | set_vec;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write forwarding and busy tracking.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = addr_width(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr
);

  logic [DATA_W-1:0]   regs   [NUM_REGS];
  logic [DATA_W-1:0]   wr_sel [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] rsv_hit;
  logic [NUM_REGS-1:0] busy;

  // Per-register write/reserve decode. Out-of-range addresses never match any
  // entry, and the ascending port loop lets the higher-index port win.
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      wr_sel[r] = '0;
      if (!(ZERO_REG && r == REG_ZERO)) begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) begin
            wr_hit[r] = 1'b1;
            wr_sel[r] = wr_data[j*DATA_W +: DATA_W];
          end
        end
        rsv_hit[r] = rsv_en && (rsv_addr == AW'(r));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_sel[r];
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clock  (clock),
    .reset  (reset),
    .set_vec(rsv_hit),
    .clr_vec(wr_hit),
    .busy   (busy)
  );

  // Read mux; the forwarded busy reflects only a same-cycle re-reservation.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (!(ZERO_REG && r == REG_ZERO) && rd_addr[i*AW +: AW] == AW'(r)) begin
          rd_data[i*DATA_W +: DATA_W] = regs[r];
          rd_busy[i]                  = busy[r];
          if (BYPASS && wr_hit[r]) begin
            rd_data[i*DATA_W +: DATA_W] = wr_sel[r];
            rd_busy[i]                  = rsv_hit[r];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two configurations driven with shared stimulus.
module tb_regfile_mp;

  // Instance 0: 24 regs, 2 write ports, zero reg, bypass.
  // Instance 1: 32 regs, 1 write port, no zero reg, no bypass.
  localparam int unsigned NREG [2] = '{24, 32};
  localparam int unsigned NWR  [2] = '{2, 1};
  localparam bit          ZR   [2] = '{1'b1, 1'b0};
  localparam bit          BYP  [2] = '{1'b1, 1'b0};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;

  always #5 clock = ~clock;

  regfile_mp #(
    .DATA_W(32), .NUM_REGS(24), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  regfile_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_b (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en[0:0]), .wr_addr(wr_addr[4:0]),
    .wr_data(wr_data[31:0]), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  typedef struct {
    bit          chk;
    string       name;
    logic [63:0] a_d;
    logic [63:0] b_d;
    logic [1:0]  a_b;
    logic [1:0]  b_b;
  } exp_t;

  exp_t        expq [$];
  logic [31:0] mem [2][32];
  bit          bsy [2][32];
  int          checks = 0;
  int          failures = 0;

  function automatic bit addr_ok(input int k, input logic [4:0] a);
    return (int'(a) < int'(NREG[k])) && !(ZR[k] && a == 5'd0);
  endfunction

  // Expected read of register ra in instance k, given the inputs currently driven.
  function automatic void model_read(input int k, input logic [4:0] ra,
                                     output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (!addr_ok(k, ra)) return;
    d = mem[k][ra];
    b = bsy[k][ra];
    if (BYP[k]) begin
      for (int j = 0; j < int'(NWR[k]); j++) begin
        if (wr_en[j] && wr_addr[j*5 +: 5] == ra) begin
          d = wr_data[j*32 +: 32];
          b = rsv_en && (rsv_addr == ra);
        end
      end
    end
  endfunction

  // State after the coming clock edge.
  function automatic void model_edge(input bit rst);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          mem[k][r] = '0;
          bsy[k][r] = 1'b0;
        end
      end else begin
        for (int j = 0; j < int'(NWR[k]); j++) begin
          if (wr_en[j] && addr_ok(k, wr_addr[j*5 +: 5])) begin
            mem[k][wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
            bsy[k][wr_addr[j*5 +: 5]] = 1'b0;
          end
        end
        if (rsv_en && addr_ok(k, rsv_addr)) bsy[k][rsv_addr] = 1'b1;
      end
    end
  endfunction

  task automatic drive(input bit rst, input logic [1:0] wen,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input bit ren, input logic [4:0] ra_rsv,
                       input logic [4:0] r0, input logic [4:0] r1, input string name);
    exp_t        e;
    logic [31:0] d0, d1;
    logic        b0, b1;
    @(posedge clock);
    #1;
    reset    = rst;
    wr_en    = wen;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    rsv_en   = ren;
    rsv_addr = ra_rsv;
    rd_addr  = {r1, r0};
    e.chk  = !rst;
    e.name = name;
    model_read(0, r0, d0, b0);
    model_read(0, r1, d1, b1);
    e.a_d = {d1, d0};
    e.a_b = {b1, b0};
    model_read(1, r0, d0, b0);
    model_read(1, r1, d1, b1);
    e.b_d = {d1, d0};
    e.b_b = {b1, b0};
    expq.push_back(e);
    model_edge(rst);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.chk) begin
          check({e.name, " a.data"}, rd_data_a, e.a_d);
          check({e.name, " a.busy"}, {62'd0, rd_busy_a}, {62'd0, e.a_b});
          check({e.name, " b.data"}, rd_data_b, e.b_d);
          check({e.name, " b.busy"}, {62'd0, rd_busy_b}, {62'd0, e.b_b});
        end
      end
    end
  end

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int wait_cycles;
    drive(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, "rst0");
    drive(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, "rst1");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd31, "reset_state");
    drive(0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd1, "wr_r5");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd5, "rd_r5");
    drive(1, 2'b01, 5'd6, 32'h11111111, 5'd0, 32'h0, 1, 5'd6, 5'd5, 5'd6, "rst_mid");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd6, "after_rst");
    drive(0, 2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0, 1, 5'd0, 5'd0, 5'd0, "zero_wr");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, "zero_next");
    drive(0, 2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd8, "bypass_r7");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd7, "r7_next");
    drive(0, 2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 0, 5'd0, 5'd9, 5'd9, "collide_r9");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd9, "r9_next");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd3, "rsv_r3");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd3, "busy_r3");
    drive(0, 2'b01, 5'd3, 32'hCAFEF00D, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd3, "wr_rsv_r3");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd3, "still_busy_r3");
    drive(0, 2'b01, 5'd3, 32'h00000033, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd3, "wr_only_r3");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd3, "free_r3");
    drive(0, 2'b10, 5'd0, 32'h0, 5'd30, 32'hFF, 1, 5'd30, 5'd30, 5'd23, "wr_oor_30");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd30, 5'd23, "rd_oor_30");
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd7, "unchanged");

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 49) == 0), 2'($urandom), rnd_addr(), $urandom,
            rnd_addr(), $urandom, 1'($urandom), rnd_addr(), rnd_addr(), rnd_addr(), "random");
    end
    drive(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd1, 5'd2, "final");

    wait_cycles = 0;
    while (expq.size() > 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    if (expq.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
